// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci-LFSR random words, range-filtered by rejection, with a valid/ready output
module lfsr_rng #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(16'hD008),
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
    parameter int               REJ_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup,
    output logic             rej_err
);
    localparam int CW = $clog2(REJ_MAX + 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] nxt;
    logic [CW-1:0]    rej_cnt;
    logic [CW-1:0]    cnt_inc;
    logic             step;
    logic             acc;

    // Next LFSR state, step qualification, range test and saturating reject count
    always_comb begin
        nxt     = {sreg[WIDTH-2:0], ^(sreg & TAPS)};
        step    = en & ~load & (~out_valid | out_ready);
        acc     = (nxt >= lo) && (nxt <= hi);
        cnt_inc = (rej_cnt == CW'(REJ_MAX)) ? rej_cnt : rej_cnt + CW'(1);
    end

    // State update: reset, then load, then step, else drain on transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg      <= SEED;
            out_data  <= '0;
            out_valid <= 1'b0;
            rej_cnt   <= '0;
            lockup    <= 1'b0;
            rej_err   <= 1'b0;
        end else if (load) begin
            sreg      <= (seed_in == '0) ? SEED : seed_in;
            lockup    <= lockup | (seed_in == '0);
            out_valid <= 1'b0;
            rej_cnt   <= '0;
        end else if (step) begin
            sreg <= nxt;
            if (acc) begin
                out_data  <= nxt;
                out_valid <= 1'b1;
                rej_cnt   <= '0;
            end else begin
                out_valid <= 1'b0;
                rej_cnt   <= cnt_inc;
                if (cnt_inc == CW'(REJ_MAX))
                    rej_err <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: randomized and directed checks of lfsr_rng against a behavioural model
module tb_lfsr_rng;
    localparam logic [15:0] TAPS = 16'hD008;
    localparam int          REJ  = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] seed_in = '0;
    logic [15:0] lo = '0;
    logic [15:0] hi = 16'hFFFF;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        lockup;
    logic        rej_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_s = 16'h0001;
    logic [15:0] m_data = '0;
    logic        m_valid = 1'b0;
    int          m_cnt = 0;
    logic        m_lock = 1'b0;
    logic        m_err = 1'b0;

    lfsr_rng dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
        .lo(lo), .hi(hi), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .lockup(lockup), .rej_err(rej_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int ones = 0;
        for (int i = 0; i < 16; i++)
            if (TAPS[i] && s[i]) ones++;
        return {s[14:0], ones[0]};
    endfunction

    task automatic tick();
        if (!rst_n) begin
            m_s = 16'h0001; m_data = '0; m_valid = 0; m_cnt = 0; m_lock = 0; m_err = 0;
        end else if (load) begin
            m_s = (seed_in == 0) ? 16'h0001 : seed_in;
            if (seed_in == 0) m_lock = 1;
            m_valid = 0;
            m_cnt = 0;
        end else if (en && (!m_valid || out_ready)) begin
            m_s = lfsr_next(m_s);
            if (m_s >= lo && m_s <= hi) begin
                m_data = m_s; m_valid = 1; m_cnt = 0;
            end else begin
                m_valid = 0;
                if (m_cnt < REJ) m_cnt++;
                if (m_cnt == REJ) m_err = 1;
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("data", out_data, m_data);
        check("valid", out_valid, m_valid);
        check("lockup", lockup, m_lock);
        check("rej_err", rej_err, m_err);
    endtask

    task automatic do_reset();
        rst_n = 0; load = 0; en = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        int ones;
        int zeros;
        do_reset();
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);

        en = 1; out_ready = 1; lo = 0; hi = 16'hFFFF;
        tick(); check("seq0", out_data, 16'h0002); check("seq0_v", out_valid, 1);
        tick(); check("seq1", out_data, 16'h0004);
        tick(); check("seq2", out_data, 16'h0008);
        tick(); check("seq3", out_data, 16'h0011);

        do_reset();
        en = 1; ones = 0; zeros = 0;
        for (int i = 0; i < 65535; i++) begin
            tick();
            if (out_data == 16'h0001) ones++;
            if (out_data == 16'h0000) zeros++;
        end
        check("period_end", out_data, 16'h0001);
        check("period_ones", ones, 1);
        check("period_zeros", zeros, 0);

        do_reset();
        en = 1; lo = 16'h0004; hi = 16'h0008;
        tick(); check("rng_rej0", out_valid, 0);
        tick(); check("rng_acc4", out_data, 16'h0004); check("rng_acc4_v", out_valid, 1);
        tick(); check("rng_acc8", out_data, 16'h0008);
        tick(); check("rng_rej11", out_valid, 0); check("rng_hold", out_data, 16'h0008);

        do_reset();
        en = 1; lo = 0; hi = 16'hFFFF; out_ready = 1;
        tick(); check("bp_first", out_data, 16'h0002);
        out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            en = 1'($urandom);
            tick();
            check("bp_data", out_data, 16'h0002);
            check("bp_valid", out_valid, 1);
        end
        en = 1; out_ready = 1;
        tick(); check("bp_next", out_data, 16'h0004);

        load = 1; seed_in = 0;
        tick(); check("lk_set", lockup, 1); check("lk_valid", out_valid, 0);
        load = 0;
        tick(); check("lk_seed1", out_data, 16'h0002);
        load = 1; seed_in = 16'h1234;
        tick(); check("lk_sticky", lockup, 1);
        load = 0;
        tick(); check("ld_step", out_data, lfsr_next(16'h1234));
        do_reset();
        check("lk_clr", lockup, 0);

        en = 1; lo = 0; hi = 0;
        for (int i = 0; i < 254; i++) tick();
        check("rej_254", rej_err, 0);
        tick(); check("rej_255", rej_err, 1); check("rej_nv", out_valid, 0);
        for (int i = 0; i < 20; i++) tick();
        rst_n = 0;
        tick(); check("midrst_err", rej_err, 0); check("midrst_data", out_data, 0);
        rst_n = 1;

        lo = 0; hi = 16'hFFFF;
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 31) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) begin
                lo = 16'($urandom);
                hi = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            end
            if ($urandom_range(0, 99) == 0) begin
                lo = 0; hi = 16'hFFFF;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised Fibonacci-LFSR random number generator with run-time seed load, run-time range bounds enforced by rejection, and a registered valid/ready output. It is the generalised successor to the fixed 14-bit LFSR: width, tap mask and seed are parameters, and it adds reset, lock-up protection and backpressure. It sits between the test-pattern/stimulus logic and any consumer that needs bounded pseudo-random words.

## Interface
- `WIDTH`, 16: LFSR and data width; legal range 3..32.
- `TAPS`, 16'hD008: feedback mask; bit i set means sreg[i] feeds the XOR. The default gives taps 16,15,13,4, which is maximal length.
- `SEED`, 1: reset value and lock-up replacement value; must be non-zero.
- `REJ_MAX`, 255: number of consecutive rejected candidates that sets `rej_err`.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `en` in 1: step enable.
- `load` in 1: load `seed_in` into the LFSR.
- `seed_in` in WIDTH: seed value used when `load`=1.
- `lo` in WIDTH: inclusive lower bound, unsigned.
- `hi` in WIDTH: inclusive upper bound, unsigned.
- `out_data` out WIDTH: accepted random word.
- `out_valid` out 1: `out_data` holds a word that has not yet been consumed.
- `out_ready` in 1: consumer accepts the word.
- `lockup` out 1: sticky flag; an all-zero seed was replaced.
- `rej_err` out 1: sticky flag; the rejection limit was reached.

## Operation
- Next-state function: next = {sreg[WIDTH-2:0], ^(sreg & TAPS)}.
- step = `en` & ~`load` & (~`out_valid` | `out_ready`).
  - When step is low, `sreg` and `out_data` are frozen.
- On step, `sreg` <= next, and the candidate is next:
  - If `lo` <= next <= `hi`: `out_data` <= next, `out_valid` <= 1, `rej_cnt` <= 0.
  - Otherwise: `out_valid` <= 0 and `rej_cnt` <= `rej_cnt`+1, saturating at `REJ_MAX`. When the count reaches `REJ_MAX`, `rej_err` <= 1.
- Without a step: if `out_valid` & `out_ready`, then `out_valid` <= 0. A transfer happens on a cycle where both are high.
- `load`=1, which has priority over step:
  - `sreg` <= `seed_in`. If `seed_in`==0, `sreg` <= `SEED` and `lockup` <= 1.
  - `out_valid` <= 0 and `rej_cnt` <= 0. `out_data` holds its value.
- `lockup` and `rej_err` clear only on reset.
- If `lo` > `hi`, no candidate is ever accepted, `out_valid` stays 0, and `rej_err` sets after `REJ_MAX` steps.
- The block never produces 0 from `sreg`. A range of [0,0] therefore always ends in `rej_err`.
- All comparisons are unsigned, full WIDTH. There is no arithmetic beyond the `rej_cnt` increment.

## Timing
- Reset (`rst_n`=0 at a clock edge) has top priority, including mid-step or mid-load:
  - `sreg`=`SEED`, `out_data`=0, `out_valid`=0, `rej_cnt`=0, `lockup`=0, `rej_err`=0.
- Latency is 1 clock: the candidate computed on a step edge is visible on `out_data`/`out_valid` immediately after that edge.
- Throughput is one candidate per clock while `out_ready`=1 or `out_valid`=0.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_valid` and `sreg` hold indefinitely, regardless of `en`.
- Simultaneous transfer and accept: the old word is consumed and the new word is presented on the same edge; no bubble.
- Simultaneous transfer and reject: `out_valid` falls to 0.
- `load` and `en` both high: the load wins and no step occurs.
- `lo`/`hi` are sampled only on step edges. Changing them does not revalidate a word already held.
- Sequence period with defaults is 65535 steps.

## Test plan
- Reset, then `en`=1, `out_ready`=1, `lo`=0, `hi`=16'hFFFF → `out_data` = 0002, 0004, 0008, 0011 on consecutive clocks, with `out_valid`=1 from the first step onward.
- Run 65535 accepted steps from reset → `sreg` returns to 0001, and no intermediate value equals 0001 or 0000.
- `lo`=0004, `hi`=0008, from reset → the first candidate 0002 is rejected (`out_valid`=0), then 0004 and 0008 are accepted, then 0011 is rejected and `out_valid` drops.
- Hold `out_ready`=0 for 10 clocks after the first word 0002 → `out_data`=0002 and `out_valid`=1 stay stable. After `out_ready` rises, the next word is 0004.
- `load`=1 with `seed_in`=0 → `sreg`=0001, `lockup`=1, `out_valid`=0. `lockup` stays 1 across further loads, and only `rst_n`=0 clears it.
- `lo`=`hi`=0000, `en`=1 → after 255 steps `rej_err`=1 and `out_valid` never asserts. Asserting `rst_n`=0 mid-run clears all outputs to their reset values on the next edge.
